// File: rtl/aud_player_i2s.sv
// Stereo PCM serialiser for a WM8731-style DAC: frame handshake with a one-frame holding
// buffer, I2S or left-justified framing against codec-driven LRCK, mono and underrun count.
module aud_player_i2s #(
  parameter int DATA_W   = 16,
  parameter int I2S_MODE = 1,
  parameter int UCNT_W   = 16
) (
  input  logic              i_bclk,
  input  logic              i_rst,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic              i_mono,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  output logic              o_ready,
  output logic              o_aud_dacdat,
  output logic              o_busy,
  output logic [UCNT_W-1:0] o_underrun_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_LEFT, ST_RIGHT} state_t;

  localparam logic [UCNT_W-1:0] UCNT_ONE = 1;

  state_t            state_q, state_d;
  logic              lrck_q, primed_q;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [DATA_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              dacdat_q, dacdat_d;
  logic              underrun_q, underrun_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  logic              left_start, right_start, accept, slot_start;
  logic [DATA_W-1:0] new_word;

  assign left_start  = primed_q && lrck_q && !i_daclrck;
  assign right_start = primed_q && !lrck_q && i_daclrck;
  assign accept      = i_valid && !buf_full_q;

  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    act_l_d    = act_l_q;
    act_r_d    = act_r_q;
    // Zero-filled shift: once a word is exhausted the line idles at 0 until the next slot
    shreg_d    = {shreg_q[DATA_W-2:0], 1'b0};
    dacdat_d   = shreg_q[DATA_W-1];
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;
    slot_start = 1'b0;
    new_word   = '0;

    if (underrun_q && (ucnt_q != '1)) begin
      ucnt_d = ucnt_q + UCNT_ONE;
    end

    if (!i_en) begin
      state_d  = ST_IDLE;
      shreg_d  = '0;
      dacdat_d = 1'b0;
    end else begin
      if (left_start && (state_q != ST_LEFT)) begin
        state_d    = ST_LEFT;
        slot_start = 1'b1;
        if (buf_full_q) begin
          act_l_d    = buf_l_q;
          act_r_d    = buf_r_q;
          buf_full_d = 1'b0;
        end else begin
          act_l_d    = '0;
          act_r_d    = '0;
          underrun_d = 1'b1;
        end
        new_word = act_l_d;
      end else if (right_start && (state_q == ST_LEFT)) begin
        state_d    = ST_RIGHT;
        slot_start = 1'b1;
        new_word   = i_mono ? act_l_q : act_r_q;
      end

      // I2S lets the pending bit of the old word go out on the edge; LJ drives the new MSB
      if (slot_start) begin
        if (I2S_MODE != 0) begin
          shreg_d = new_word;
        end else begin
          dacdat_d = new_word[DATA_W-1];
          shreg_d  = {new_word[DATA_W-2:0], 1'b0};
        end
      end
    end

    // A handshake on an empty-buffer left-start lands after the underrun load
    if (accept) begin
      buf_full_d = 1'b1;
      buf_l_d    = i_left;
      buf_r_d    = i_right;
    end
  end

  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      lrck_q     <= 1'b0;
      primed_q   <= 1'b0;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      act_l_q    <= '0;
      act_r_q    <= '0;
      shreg_q    <= '0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      lrck_q     <= i_daclrck;
      primed_q   <= 1'b1;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      act_l_q    <= act_l_d;
      act_r_q    <= act_r_d;
      shreg_q    <= shreg_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign o_ready        = !buf_full_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_aud_dacdat   = dacdat_q;
  assign o_underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_aud_player_i2s.sv
// Bench for aud_player_i2s: three instances (I2S/16, LJ/24, I2S/16 with 2-bit counter)
// share stimulus; a slot-timeline model checks every cycle, plus vector tables and corner cases.
module tb_aud_player_i2s;

  logic bclk = 1'b0;
  always #5 bclk = ~bclk;

  logic        rst, lrck, en, mono, valid;
  logic [31:0] left32, right32;

  logic        ready_a, dac_a, busy_a;
  logic [15:0] ucnt_a;
  logic        ready_b, dac_b, busy_b;
  logic [15:0] ucnt_b;
  logic        ready_c, dac_c, busy_c;
  logic [1:0]  ucnt_c;

  aud_player_i2s #(.DATA_W(16), .I2S_MODE(1), .UCNT_W(16)) u_a (
    .i_bclk(bclk), .i_rst(rst), .i_daclrck(lrck), .i_en(en), .i_mono(mono),
    .i_valid(valid), .i_left(left32[15:0]), .i_right(right32[15:0]),
    .o_ready(ready_a), .o_aud_dacdat(dac_a), .o_busy(busy_a), .o_underrun_cnt(ucnt_a));

  aud_player_i2s #(.DATA_W(24), .I2S_MODE(0), .UCNT_W(16)) u_b (
    .i_bclk(bclk), .i_rst(rst), .i_daclrck(lrck), .i_en(en), .i_mono(mono),
    .i_valid(valid), .i_left(left32[23:0]), .i_right(right32[23:0]),
    .o_ready(ready_b), .o_aud_dacdat(dac_b), .o_busy(busy_b), .o_underrun_cnt(ucnt_b));

  aud_player_i2s #(.DATA_W(16), .I2S_MODE(1), .UCNT_W(2)) u_c (
    .i_bclk(bclk), .i_rst(rst), .i_daclrck(lrck), .i_en(en), .i_mono(mono),
    .i_valid(valid), .i_left(left32[15:0]), .i_right(right32[15:0]),
    .o_ready(ready_c), .o_aud_dacdat(dac_c), .o_busy(busy_c), .o_underrun_cnt(ucnt_c));

  int checks = 0;
  int failures = 0;
  int slot_len = 32;
  int lr_phase = 63;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frame/buffer bookkeeping plus a timeline of slot starts;
  // each serial bit is derived from its distance to the governing slot start.
  int          cyc_n = 0;
  bit          m_primed = 0, m_lrck_prev = 0, m_buf_full = 0, m_pend = 0;
  int          m_mode = 0;
  int          m_raw = 0;
  logic [31:0] m_buf_l = 0, m_buf_r = 0, m_act_l = 0, m_act_r = 0;
  bit          cur_v = 0, prev_v = 0;
  int          cur_start = 0, prev_start = 0;
  logic [31:0] cur_word = 0, prev_word = 0;

  function automatic void push_slot(input logic [31:0] w);
    prev_v     = cur_v;
    prev_start = cur_start;
    prev_word  = cur_word;
    cur_v      = 1'b1;
    cur_start  = cyc_n;
    cur_word   = w;
  endfunction

  function automatic void model_step();
    bit ls, rs, acc;
    cyc_n++;
    if (rst) begin
      m_primed = 0; m_lrck_prev = 0; m_mode = 0; m_buf_full = 0;
      cur_v = 0; prev_v = 0; m_pend = 0; m_raw = 0;
      return;
    end
    if (m_pend) m_raw++;
    m_pend = 0;
    ls  = m_primed && m_lrck_prev && !lrck;
    rs  = m_primed && !m_lrck_prev && lrck;
    acc = valid && !m_buf_full;
    if (!en) begin
      m_mode = 0; cur_v = 0; prev_v = 0;
    end else if (ls && m_mode != 1) begin
      m_mode = 1;
      if (m_buf_full) begin
        m_act_l = m_buf_l; m_act_r = m_buf_r; m_buf_full = 0;
      end else begin
        m_act_l = 0; m_act_r = 0; m_pend = 1;
      end
      push_slot(m_act_l);
    end else if (rs && m_mode == 1) begin
      m_mode = 2;
      push_slot(mono ? m_act_l : m_act_r);
    end
    if (acc) begin
      m_buf_full = 1; m_buf_l = left32; m_buf_r = right32;
    end
    m_primed = 1;
    m_lrck_prev = lrck;
  endfunction

  function automatic logic exp_bit(input int w, input int off);
    int st, idx;
    logic [31:0] wd;
    if (cur_v && cur_start + off <= cyc_n) begin
      st = cur_start; wd = cur_word;
    end else if (prev_v && prev_start + off <= cyc_n) begin
      st = prev_start; wd = prev_word;
    end else begin
      return 1'b0;
    end
    idx = cyc_n - st - off;
    if (idx >= w) return 1'b0;
    return wd[w-1-idx];
  endfunction

  function automatic logic [18:0] exp_vec(input int w, input int off, input int umax);
    int u;
    u = (m_raw > umax) ? umax : m_raw;
    return {(m_mode != 0), !m_buf_full, exp_bit(w, off), 16'(u)};
  endfunction

  initial begin
    forever begin
      @(posedge bclk);
      model_step();
      #1;
      check("model_a", {busy_a, ready_a, dac_a, ucnt_a}, exp_vec(16, 1, 65535));
      check("model_b", {busy_b, ready_b, dac_b, ucnt_b}, exp_vec(24, 0, 65535));
      check("model_c", {busy_c, ready_c, dac_c, 14'd0, ucnt_c}, exp_vec(16, 1, 3));
    end
  end

  // One BCLK: wait for the falling edge, then advance the codec LRCK pattern
  task automatic cyc();
    @(negedge bclk);
    lr_phase = (lr_phase + 1) % (2 * slot_len);
    lrck = (lr_phase >= slot_len);
  endtask

  task automatic run_to_left_start();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (lr_phase != 0 && n < 400);
  endtask

  task automatic capture(input int n, output logic [63:0] ba, output logic [63:0] bb,
                         output logic rdy0);
    ba = '0; bb = '0; rdy0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (i == 0) rdy0 = ready_a;
      ba = {ba[62:0], dac_a};
      bb = {bb[62:0], dac_b};
    end
  endtask

  task automatic preload(input logic [31:0] l, input logic [31:0] r);
    check("ready_before_load", ready_a, 1'b1);
    left32 = l; right32 = r; valid = 1'b1;
    cyc();
    valid = 1'b0;
    check("ready_after_load", ready_a, 1'b0);
  endtask

  task automatic do_reset(input int s);
    rst = 1'b1; en = 1'b0; valid = 1'b0;
    cyc();
    slot_len = s; lr_phase = 2 * s - 1; lrck = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc(); cyc();
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        mono;
    logic [63:0] exp_bits;
  } vec_t;

  initial begin
    vec_t        tbl[4];
    logic [63:0] ba, bb;
    logic        rdy0;
    int          choices[4];
    int          sl;

    tbl[0] = '{16'hA5C3, 16'h0F0F, 1'b0, {1'b0, 16'hA5C3, 16'h0000, 16'h0F0F, 15'h0}};
    tbl[1] = '{16'h1234, 16'hFFFF, 1'b1, {1'b0, 16'h1234, 16'h0000, 16'h1234, 15'h0}};
    tbl[2] = '{16'h8001, 16'h7FFE, 1'b0, {1'b0, 16'h8001, 16'h0000, 16'h7FFE, 15'h0}};
    tbl[3] = '{16'hFFFF, 16'h0000, 1'b1, {1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 15'h0}};
    choices = '{16, 20, 24, 32};

    rst = 1'b1; en = 1'b0; mono = 1'b0; valid = 1'b0;
    left32 = '0; right32 = '0; lrck = 1'b1;
    cyc(); cyc();
    check("reset_a", {busy_a, ready_a, dac_a, ucnt_a}, {1'b0, 1'b1, 1'b0, 16'd0});
    check("reset_c", {busy_c, ready_c, dac_c, ucnt_c}, {1'b0, 1'b1, 1'b0, 2'd0});
    rst = 1'b0;
    cyc(); cyc(); cyc();

    // Frame vectors: preload, enable, capture both slots of the I2S/16 instance
    for (int i = 0; i < 4; i++) begin
      mono = tbl[i].mono;
      preload({16'h0, tbl[i].l}, {16'h0, tbl[i].r});
      en = 1'b1;
      run_to_left_start();
      capture(64, ba, bb, rdy0);
      check("vec_bits", ba, tbl[i].exp_bits);
      check("vec_ready_at_ls", rdy0, 1'b1);
      $display("vec %0d: L=%h R=%h mono=%0d bits=%h", i, tbl[i].l, tbl[i].r, tbl[i].mono, ba);
    end
    mono = 1'b0;

    // Left-justified 24-bit: MSB on the left-start edge, LSB 23 BCLKs later
    preload(32'h0080_0001, 32'h0);
    run_to_left_start();
    capture(32, ba, bb, rdy0);
    check("lj_bits", bb, 64'h0000_0000_8000_0100);
    $display("lj: bits=%h", bb[31:0]);

    // Underrun: three empty frames, count appears one cycle after the left-start
    do_reset(32);
    en = 1'b1;
    run_to_left_start();
    run_to_left_start();
    run_to_left_start();
    cyc();
    check("ucnt_at_k", ucnt_a, 16'd2);
    cyc();
    check("ucnt_after_3", ucnt_a, 16'd3);
    check("ucnt_c_after_3", ucnt_c, 2'd3);
    preload(32'h5A5A, 32'h3C3C);
    run_to_left_start();
    cyc(); cyc(); cyc();
    check("ucnt_hold", ucnt_a, 16'd3);
    run_to_left_start();
    run_to_left_start();
    cyc(); cyc();
    check("ucnt_after_5", ucnt_a, 16'd5);
    check("ucnt_c_saturated", ucnt_c, 2'd3);
    $display("underrun: cnt_a=%0d cnt_c=%0d", ucnt_a, ucnt_c);

    // 16 BCLK slots: the LSB of each word lands on the next slot-start edge
    do_reset(16);
    en = 1'b1;
    preload(32'hC003, 32'h8001);
    run_to_left_start();
    capture(33, ba, bb, rdy0);
    check("short_slot_bits", ba, {31'b0, 1'b0, 16'hC003, 16'h8001});
    $display("short slot: bits=%h", ba[32:0]);

    // Disable mid left slot
    do_reset(32);
    en = 1'b1;
    preload(32'hFFFF, 32'hFFFF);
    run_to_left_start();
    repeat (5) cyc();
    check("en_pre_bit", dac_a, 1'b1);
    en = 1'b0;
    cyc();
    check("en_off_dac_a", dac_a, 1'b0);
    check("en_off_dac_b", dac_b, 1'b0);
    check("en_off_busy", busy_a, 1'b0);
    $display("disable: dac=%0d busy=%0d", dac_a, busy_a);

    // Reset mid right slot with a frame waiting in the buffer
    en = 1'b1;
    preload(32'hFFFF, 32'hFFFF);
    run_to_left_start();
    cyc();
    preload(32'h1111, 32'h2222);
    repeat (38) cyc();
    check("rst_pre_bit", dac_a, 1'b1);
    rst = 1'b1;
    cyc();
    check("rst_mid_a", {busy_a, ready_a, dac_a, ucnt_a}, {1'b0, 1'b1, 1'b0, 16'd0});
    check("rst_mid_b", {busy_b, ready_b, dac_b, ucnt_b}, {1'b0, 1'b1, 1'b0, 16'd0});
    rst = 1'b0;
    $display("mid-frame reset: ready=%0d busy=%0d", ready_a, busy_a);

    // Randomised traffic against the model
    for (int r = 0; r < 6; r++) begin
      sl = choices[$urandom_range(3)];
      do_reset(sl);
      en = 1'b1;
      for (int i = 0; i < 800; i++) begin
        valid   = ($urandom_range(2) == 0);
        left32  = $urandom;
        right32 = $urandom;
        if ($urandom_range(99) == 0) en = !en;
        else if (!en && $urandom_range(15) == 0) en = 1'b1;
        if ($urandom_range(39) == 0) mono = !mono;
        rst = ($urandom_range(499) == 0);
        cyc();
      end
      rst = 1'b0; valid = 1'b0;
      $display("random round %0d: slot=%0d checks=%0d", r, sl, checks);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aud_player_i2s.md
# aud_player_i2s

Parametrised serial DAC player that shifts stereo PCM frames out to the codec's DACDAT pin, framed by the codec-generated DACLRCK and clocked by BCLK. It sits between the audio DSP (sample producer) and the WM8731 DAC interface. It adds a valid/ready frame handshake, a one-frame holding buffer, I2S and left-justified framing, mono duplication, and underrun accounting.

## Interface
- DATA_W, 16: sample width in bits, 8..32.
- I2S_MODE, 1: 1 = Philips I2S (MSB one BCLK after LRCK edge); 0 = left-justified (MSB on LRCK edge).
- UCNT_W, 16: underrun counter width.

Ports:
- i_bclk  in  1  bit clock; the only clock; all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_daclrck  in  1  frame clock from codec, sampled on posedge i_bclk; 0 = left slot, 1 = right slot.
- i_en  in  1  playback enable.
- i_mono  in  1  1 = right slot transmits the left sample.
- i_valid  in  1  producer offers a frame.
- i_left  in  DATA_W  signed left sample, two's complement.
- i_right  in  DATA_W  signed right sample.
- o_ready  out  1  holding buffer empty; frame accepted when i_valid && o_ready on a posedge.
- o_aud_dacdat  out  1  serial data to codec, registered.
- o_busy  out  1  a frame is currently being shifted (state LEFT or RIGHT).
- o_underrun_cnt  out  UCNT_W  saturating count of frames played as silence while enabled.

## Operation
- Edge detect: lrck_q holds the previous i_daclrck sample, and a primed flag is set one cycle after reset. A left-start is lrck_q=1, i_daclrck=0 with primed set. A right-start is lrck_q=0, i_daclrck=1 with primed set. No edge is recognised on the first cycle after reset.
- Holding buffer: one frame (left, right). o_ready = !buf_full. Accepting a frame sets buf_full.
- States:
  - IDLE: go to LEFT on a left-start with i_en=1.
  - LEFT: go to RIGHT on a right-start.
  - RIGHT: go to LEFT on a left-start. If i_en=0, go to IDLE.
  - i_en=0 in any state forces IDLE on the next posedge.
- Frame load, at every left-start taken with i_en=1:
  - If buf_full: copy the buffer to the active frame and clear buf_full. o_ready rises on the following cycle.
  - If the buffer is empty: the active frame is all zeros, and o_underrun_cnt increments, saturating at all-ones.
  - If a handshake lands on the same edge as an empty-buffer left-start: the frame underruns and the accepted data plays in the next frame.
- Active right word is left when i_mono=1, otherwise right. i_mono is sampled at the right-start.
- Bit counter: zeroed at each slot start, increments per BCLK, saturates at DATA_W. After DATA_W bits, o_aud_dacdat = 0 until the next slot start.
- Short slot (fewer BCLKs than DATA_W): the word is truncated and the next slot starts cleanly.
- i_en=0: o_aud_dacdat = 0 from the next posedge. The buffer and handshake stay live. No underrun counting.
- Reset values: o_aud_dacdat=0, o_ready=1 (buffer empty), o_busy=0, o_underrun_cnt=0, state IDLE, primed=0, lrck_q=0.
- Reset mid-frame: all of the above apply immediately, and any buffered frame is discarded.

## Timing
- Let slot start be detected at posedge k.
- I2S_MODE=1:
  - At posedge k, o_aud_dacdat drives the pending bit of the previous word, or 0 if that word is exhausted.
  - MSB of the new word appears at posedge k+1, LSB at posedge k+DATA_W.
  - The last bit of the new word therefore overlaps the next slot edge when the slot is exactly DATA_W bits.
- I2S_MODE=0: MSB at posedge k, LSB at posedge k+DATA_W-1.
- o_underrun_cnt updates at posedge k+1 after an underrunning left-start.
- Handshake latency: a frame accepted at posedge j plays from the first left-start strictly after j.
- Throughput: one frame per LRCK period. The producer has a full frame period to refill.

## Test plan
- I2S, DATA_W=16, 32 BCLK/slot: preload L=16'hA5C3, R=16'h0F0F, then enable. Expect DACDAT to show A5C3 MSB-first starting 1 BCLK after the falling LRCK edge, then 16 zeros, then 0F0F starting 1 BCLK after the rising edge. o_ready re-asserts 1 cycle after the left-start.
- Left-justified, DATA_W=24, 32 BCLK/slot: L=24'h800001. Expect the MSB bit 1 exactly at the left-start posedge, bit 1 again 23 BCLKs later, then zeros.
- Underrun: enable with the buffer empty for 3 frames. Expect all-zero DACDAT and o_underrun_cnt=3. Then supply a frame; it plays at the next left-start and the count holds at 3.
- Mono: i_mono=1 with L=16'h1234, R=16'hFFFF. Expect both slots to carry 1234.
- Boundaries, case 1: UCNT_W=2 with 5 underruns → o_underrun_cnt saturates at 3.
- Boundaries, case 2: 16 BCLK/slot in I2S mode → the LSB lands on the next slot-start posedge.
- Boundaries, case 3: deassert i_en mid-left-slot → DACDAT is 0 on the next posedge and the state returns to IDLE.
- Boundaries, case 4: assert i_rst mid-right-slot → all outputs take reset values on the next posedge.
